// File: rtl/switch_debounce_filter_if.sv
// Bundles the switch-conditioning signals: the raw level going in and the clean level,
// the press/release strobes and the busy flag coming out.
interface switch_debounce_filter_if;
    logic i_Switch;
    logic o_Switch;
    logic o_Press;
    logic o_Release;
    logic o_Busy;

    modport master (
        output i_Switch,
        input  o_Switch,
        input  o_Press,
        input  o_Release,
        input  o_Busy
    );

    modport slave (
        input  i_Switch,
        output o_Switch,
        output o_Press,
        output o_Release,
        output o_Busy
    );
endinterface

// File: rtl/switch_debounce_filter.sv
// Synchronises and debounces one mechanical switch and emits one-cycle press/release strobes.
// Optional auto-repeat of o_Press while held: define SWITCH_DEBOUNCE_REPEAT_EN.
module switch_debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES     = 250000,
    parameter int unsigned SYNC_STAGES         = 2,
    parameter logic        INIT_LEVEL          = 1'b0
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_CYCLES = 12500000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 2500000
`endif
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_N,
    switch_debounce_filter_if.slave  sw
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LO,
        SETTLE_HI,
        STABLE_HI,
        SETTLE_LO
    } state_e;

    localparam state_e INIT_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   switch_q, switch_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   busy_q, busy_d;
    logic                   sync_last;

`ifdef SWITCH_DEBOUNCE_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
`endif

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sw.i_Switch};
        state_d   = state_q;
        count_d   = '0;
        switch_d  = switch_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        busy_d    = busy_q;
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
        // Anything other than a held STABLE_HI clears repeat timing back to the initial delay.
        rpt_d       = '0;
        rpt_first_d = 1'b1;
`endif

        case (state_q)
            STABLE_LO: begin
                if (sync_last) begin
                    state_d = SETTLE_HI;
                    busy_d  = 1'b1;
                end
            end

            STABLE_HI: begin
                if (!sync_last) begin
                    state_d = SETTLE_LO;
                    busy_d  = 1'b1;
                end else begin
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
                    if (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST)) begin
                        press_d     = 1'b1;
                        rpt_d       = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_d       = rpt_q + 1'b1;
                        rpt_first_d = rpt_first_q;
                    end
`else
                    press_d = 1'b0;
`endif
                end
            end

            SETTLE_HI: begin
                if (!sync_last) begin
                    state_d = STABLE_LO;
                    busy_d  = 1'b0;
                end else if (count_q == CNT_LAST) begin
                    state_d  = STABLE_HI;
                    switch_d = 1'b1;
                    press_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                end
            end

            SETTLE_LO: begin
                if (sync_last) begin
                    state_d = STABLE_HI;
                    busy_d  = 1'b0;
                end else if (count_q == CNT_LAST) begin
                    state_d   = STABLE_LO;
                    switch_d  = 1'b0;
                    release_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                end
            end

            default: begin
                state_d = INIT_STATE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            sync_q      <= {SYNC_STAGES{INIT_LEVEL}};
            state_q     <= INIT_STATE;
            count_q     <= '0;
            switch_q    <= INIT_LEVEL;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            count_q     <= count_d;
            switch_q    <= switch_d;
            press_q     <= press_d;
            release_q   <= release_d;
            busy_q      <= busy_d;
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign sw.o_Switch  = switch_q;
    assign sw.o_Press   = press_q;
    assign sw.o_Release = release_q;
    assign sw.o_Busy    = busy_q;

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Directed bench for switch_debounce_filter with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Outputs are packed as {o_Switch, o_Press, o_Release, o_Busy}.
module tb_switch_debounce_filter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    switch_debounce_filter_if sw_if ();

    switch_debounce_filter #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2),
        .INIT_LEVEL(1'b0)
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
        ,
        .REPEAT_DELAY_CYCLES(8),
        .REPEAT_RATE_CYCLES(3)
`endif
    ) dut (
        .i_Clk  (clk),
        .i_Rst_N(rst_n),
        .sw     (sw_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       sw;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [44];

    function automatic logic [3:0] outs();
        return {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release, sw_if.o_Busy};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (sw,press,rel,busy) at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, then sample 1 ns after the rising edge that consumes them.
    task automatic step(input logic r, input logic s);
        rst_n = r;
        sw_if.i_Switch = s;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] e;

    initial begin
        sw_if.i_Switch = 1'b0;

        // Reset with switch high, clean press, short glitch, release, bounce then press.
        tbl[0]  = '{1'b0, 1'b1, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 1'b1, 4'b0000};
        tbl[4]  = '{1'b1, 1'b1, 4'b0000};
        tbl[5]  = '{1'b1, 1'b1, 4'b0001};
        tbl[6]  = '{1'b1, 1'b1, 4'b0001};
        tbl[7]  = '{1'b1, 1'b1, 4'b0001};
        tbl[8]  = '{1'b1, 1'b1, 4'b0001};
        tbl[9]  = '{1'b1, 1'b1, 4'b1100};
        tbl[10] = '{1'b1, 1'b1, 4'b1000};
        tbl[11] = '{1'b1, 1'b1, 4'b1000};
        tbl[12] = '{1'b1, 1'b0, 4'b1000};
        tbl[13] = '{1'b1, 1'b0, 4'b1000};
        tbl[14] = '{1'b1, 1'b0, 4'b1001};
        tbl[15] = '{1'b1, 1'b1, 4'b1001};
        tbl[16] = '{1'b1, 1'b1, 4'b1001};
        tbl[17] = '{1'b1, 1'b1, 4'b1000};
        tbl[18] = '{1'b1, 1'b1, 4'b1000};
        tbl[19] = '{1'b1, 1'b0, 4'b1000};
        tbl[20] = '{1'b1, 1'b0, 4'b1000};
        tbl[21] = '{1'b1, 1'b0, 4'b1001};
        tbl[22] = '{1'b1, 1'b0, 4'b1001};
        tbl[23] = '{1'b1, 1'b0, 4'b1001};
        tbl[24] = '{1'b1, 1'b0, 4'b1001};
        tbl[25] = '{1'b1, 1'b0, 4'b0010};
        tbl[26] = '{1'b1, 1'b0, 4'b0000};
        tbl[27] = '{1'b1, 1'b1, 4'b0000};
        tbl[28] = '{1'b1, 1'b1, 4'b0000};
        tbl[29] = '{1'b1, 1'b0, 4'b0001};
        tbl[30] = '{1'b1, 1'b0, 4'b0001};
        tbl[31] = '{1'b1, 1'b1, 4'b0000};
        tbl[32] = '{1'b1, 1'b1, 4'b0000};
        tbl[33] = '{1'b1, 1'b0, 4'b0001};
        tbl[34] = '{1'b1, 1'b0, 4'b0001};
        tbl[35] = '{1'b1, 1'b1, 4'b0000};
        tbl[36] = '{1'b1, 1'b1, 4'b0000};
        tbl[37] = '{1'b1, 1'b1, 4'b0001};
        tbl[38] = '{1'b1, 1'b1, 4'b0001};
        tbl[39] = '{1'b1, 1'b1, 4'b0001};
        tbl[40] = '{1'b1, 1'b1, 4'b0001};
        tbl[41] = '{1'b1, 1'b1, 4'b1100};
        tbl[42] = '{1'b1, 1'b1, 4'b1000};
        tbl[43] = '{1'b1, 1'b1, 4'b1000};

        @(negedge clk);
        for (int i = 0; i < 44; i++) begin
            step(tbl[i].rst_n, tbl[i].sw);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Reset during SETTLE_HI abandons the candidate with no pulse.
        step(1'b0, 1'b0);
        check("rst_lo", outs(), 4'b0000);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("settle_a", outs(), 4'b0001);
        step(1'b1, 1'b1);
        check("settle_b", outs(), 4'b0001);
        step(1'b0, 1'b0);
        check("rst_mid", outs(), 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("post_rst%0d", i), outs(), 4'b0000);
        end

        // Clean press at nominal latency, then held; repeats only with the macro.
        for (int i = 0; i < 26; i++) begin
            step(1'b1, 1'b1);
            e = 4'b0000;
            if (i >= 2 && i <= 5) e[0] = 1'b1;
            if (i >= 6) e[3] = 1'b1;
            if (i == 6) e[2] = 1'b1;
`ifdef SWITCH_DEBOUNCE_REPEAT_EN
            if (i == 14 || i == 17 || i == 20 || i == 23) e[2] = 1'b1;
`endif
            check($sformatf("hold%0d", i), outs(), e);
        end

        // Release: single o_Release, no press once settling low has begun.
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b0);
            if (j >= 2) begin
                e = 4'b1000;
                if (j <= 5) e[0] = 1'b1;
                if (j >= 6) e[3] = 1'b0;
                if (j == 6) e[1] = 1'b1;
                check($sformatf("rel%0d", j), outs(), e);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
